store_buffer: RTL
=================

Name: store_buffer

Overview:
- Posted-write FIFO between the MEM-stage byte-enable generator and the data memory.
- Accepts stores (word address, byte enables, unaligned low-lane data, PC) and drains them to data memory one per cycle when memory is ready.
- Lets the pipeline retire stores without waiting on memory.
- Flags loads that hit a pending store word, so the hazard unit stalls them until the word has drained.

Parameters:
DEPTH, 4, number of buffer entries; power of two, 2..16
PTR_W, 2, log2(DEPTH); pointer width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  MEM stage presents a store this cycle
st_addr  input  32  store byte address
st_be  input  4  byte enables (0001/0010/0100/1000/0011/1100/1111)
st_data  input  32  store data, DM format (byte in [7:0], half in [15:0])
st_pc  input  32  PC of the store instruction
st_ready  output  1  buffer can accept a store this cycle
ld_valid  input  1  MEM stage presents a load this cycle
ld_addr  input  32  load byte address
ld_hit  output  1  a pending entry targets the same word as ld_addr
dm_we  output  1  head entry valid; write request to data memory
dm_addr  output  32  head address, with [1:0] forced to 00
dm_be  output  4  head byte enables
dm_din  output  32  head data
dm_pc  output  32  head PC, for the write trace
dm_ready  input  1  data memory accepts the write this cycle
count  output  PTR_W+1  number of valid entries
empty  output  1  count == 0

Behaviour:
- Storage: DEPTH entries of {addr[31:2], be, data, pc}, plus head/tail pointers and count.
- Reset (reset low, asynchronous):
  - head = tail = count = 0.
  - All entries are invalidated and all outputs are combinationally 0.
  - Exceptions: st_ready=1 and empty=1.
  - Entry payload contents need not be cleared.
- Reset mid-operation discards all pending stores; none reach memory, and dm_we drops immediately.
- push = st_valid & st_ready; st_ready = (count != DEPTH).
  - When the buffer is full, st_ready stays 0 even if a pop happens that cycle. There is no full-pass-through.
- pop = dm_we & dm_ready; dm_we = (count != 0).
- dm_addr/dm_be/dm_din/dm_pc are driven from the head entry registers, with no combinational path from st_* inputs.
  - An accepted store is visible on dm_* at the earliest 1 cycle after acceptance (minimum latency 1).
- Push writes the entry at tail, then tail <= tail+1 modulo DEPTH. Pop advances head <= head+1 modulo DEPTH.
- Pointers wrap naturally at DEPTH, and drain order is strict FIFO.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. This is legal whenever count is between 1 and DEPTH-1.
- Push with st_valid while st_ready=0 is ignored. The upstream stage must hold the store and stall.
- dm_* must stay stable while dm_we=1 and dm_ready=0.
- st_be is stored as given; the block performs no realignment. An st_be value outside the legal set is stored and forwarded unchanged.
- ld_hit = ld_valid & OR over valid entries of (entry.addr[31:2] == ld_addr[31:2]).
  - Word granularity; byte-enable overlap is not checked.
  - Combinational on the current registered state.
- A store pushed in the same cycle is not visible to ld_hit; the hazard unit covers that case separately.
- The head entry being popped in the current cycle still counts for ld_hit in that cycle. It no longer counts from the next cycle.
- empty = (count == 0); count is a direct register output.
- No bypass forwarding of store data to loads.

Test Plan:
- Reset and idle: hold reset low, then release. Require dm_we=0, st_ready=1, empty=1, count=0; ld_valid=1 with any address gives ld_hit=0.
- Single store, dm_ready tied to 1:
  - Stimulus: push addr=0x0000_1006, be=1100, data=0x0000_BEEF, pc=0x3000.
  - Next cycle: dm_we=1, dm_addr=0x0000_1004, dm_be=1100, dm_din=0x0000_BEEF, dm_pc=0x3000.
  - Following cycle: empty=1.
- Fill and backpressure, dm_ready=0:
  - Push 5 stores back to back. The first 4 are accepted and count=4; st_ready=0 during the 5th, which is not accepted.
  - Raise dm_ready: entries drain in push order, one per cycle.
  - st_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop with wrap: dm_ready=1 and a continuous push stream of 10 stores. count holds at 1, pointers wrap twice, and all 10 appear on dm_* in order with matching PCs.
- Load hazard:
  - Buffer holds addr 0x2000 (be=0001), dm_ready=0.
  - Loads at 0x2003 and 0x2000 give ld_hit=1; a load at 0x2004 gives ld_hit=0.
  - After the entry pops, a load at 0x2003 gives ld_hit=0.
- Reset mid-operation: with 3 entries pending and dm_ready=0, pulse reset low between clock edges. dm_we and count go to 0 immediately, and no entry is written to memory after reset is released.

Source files
------------

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO between MEM stage and data memory
// Drains one store per cycle; flags loads hitting a pending store word.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [3:0]       st_be,
    input  logic [31:0]      st_data,
    input  logic [31:0]      st_pc,
    output logic             st_ready,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic             dm_we,
    output logic [31:0]      dm_addr,
    output logic [3:0]       dm_be,
    output logic [31:0]      dm_din,
    output logic [31:0]      dm_pc,
    input  logic             dm_ready,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [29:0]      r_addr [DEPTH];
    logic [3:0]       r_be   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc   [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid_nxt;
    logic             w_hit;
    logic             w_unused_bits;

    // Byte offsets are irrelevant at word granularity.
    assign w_unused_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready = (r_count != FULL_CNT);
    assign dm_we    = (r_count != '0);
    assign w_push   = st_valid & st_ready;
    assign w_pop    = dm_we & dm_ready;
    assign count    = r_count;
    assign empty    = (r_count == '0);

    // Payload is not reset; gating by dm_we keeps outputs at zero while empty.
    assign dm_addr = dm_we ? {r_addr[r_head], 2'b00} : 32'h0;
    assign dm_be   = dm_we ? r_be[r_head]            : 4'h0;
    assign dm_din  = dm_we ? r_data[r_head]          : 32'h0;
    assign dm_pc   = dm_we ? r_pc[r_head]            : 32'h0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr[31:2];
            r_be[r_tail]   <= st_be;
            r_data[r_tail] <= st_data;
            r_pc[r_tail]   <= st_pc;
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        if (w_pop)
            w_valid_nxt[r_head] = 1'b0;
        if (w_push)
            w_valid_nxt[r_tail] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_push)
                r_tail <= r_tail + PTR_W'(1);
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            if (w_push && !w_pop)
                r_count <= r_count + (PTR_W+1)'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == ld_addr[31:2]))
                w_hit = 1'b1;
        end
    end

    assign ld_hit = ld_valid & w_hit;

endmodule
